// File: rtl/scan_move_sequencer.sv
// Purpose: walks the 48-observation scan schedule and issues one face turn at a time for each setup request.
// Latency: request -> LOAD -> first move (or SETTLE); stable pulse SETTLE_CYCLES after the last move_done.
// Backpressure: move_code is held with move_valid until move_ready; requests while busy set protocol_error.
// Build option: SCAN_SETTLE_TIMER_EN enables the SETTLE_CYCLES countdown; without it SETTLE lasts one cycle.
module scan_move_sequencer #(
  parameter logic [15:0] SETTLE_CYCLES = 16'd5000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send_setup_moves,
  input  logic       move_ready,
  input  logic       move_done,
  output logic       move_valid,
  output logic [4:0] move_code,
  output logic       color_sensor_stable,
  output logic [5:0] step,
  output logic       scan_done,
  output logic       protocol_error
);

  typedef enum logic [2:0] {
    WAIT_REQ  = 3'd0,
    LOAD      = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    SETTLE    = 3'd4,
    FINISHED  = 3'd5
  } state_t;

  // Move codes: {face, turn}; face U=0 L=1 F=2 R=3 B=4, turn 1=CW 2=CCW 3=half.
  localparam logic [4:0] U_CW  = 5'b00001;
  localparam logic [4:0] U_CCW = 5'b00010;
  localparam logic [4:0] L_CW  = 5'b00101;
  localparam logic [4:0] L_CCW = 5'b00110;
  localparam logic [4:0] L_H   = 5'b00111;
  localparam logic [4:0] F_CW  = 5'b01001;
  localparam logic [4:0] F_CCW = 5'b01010;
  localparam logic [4:0] F_H   = 5'b01011;
  localparam logic [4:0] R_CW  = 5'b01101;
  localparam logic [4:0] R_CCW = 5'b01110;
  localparam logic [4:0] R_H   = 5'b01111;
  localparam logic [4:0] B_CW  = 5'b10001;
  localparam logic [4:0] B_CCW = 5'b10010;
  localparam logic [4:0] B_H   = 5'b10011;

  // Setup list of a batch, move 0 in the least significant 5 bits.
  function automatic logic [29:0] setup_list(input logic [3:0] b);
    case (b)
      4'd1:    setup_list = {20'd0, B_CCW, F_CW};
      4'd2:    setup_list = {20'd0, R_CW, L_CCW};
      4'd3:    setup_list = {20'd0, B_CW, F_CCW};
      4'd4:    setup_list = {20'd0, R_CCW, L_CW};
      4'd5:    setup_list = {20'd0, R_H, L_H};
      4'd7:    setup_list = {B_CCW, F_CW, U_CW, L_CW, B_CCW, F_CW};
      4'd8:    setup_list = {R_CW, L_CCW, U_CCW, F_CW, R_CW, L_CCW};
      4'd9:    setup_list = {B_CW, F_CCW, U_CW, R_CW, B_CW, F_CCW};
      4'd10:   setup_list = {R_CCW, L_CW, U_CW, B_CCW, R_CCW, L_CW};
      4'd11:   setup_list = {10'd0, B_H, F_H, L_H, R_H};
      default: setup_list = 30'd0;
    endcase
  endfunction

  function automatic logic [3:0] setup_len(input logic [3:0] b);
    case (b)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: setup_len = 4'd2;
      4'd7, 4'd8, 4'd9, 4'd10:      setup_len = 4'd6;
      4'd11:                        setup_len = 4'd4;
      default:                      setup_len = 4'd0;
    endcase
  endfunction

  function automatic logic [4:0] pick(input logic [29:0] lst, input logic [3:0] k);
    pick = 5'd0;
    for (int m = 0; m < 6; m++) begin
      if (4'(m) == k) pick = lst[m*5 +: 5];
    end
  endfunction

  // Undo direction: CW and CCW swap, half turns stay.
  function automatic logic [4:0] invert(input logic [4:0] c);
    invert = c;
    if (c[1:0] == 2'd1)      invert[1:0] = 2'd2;
    else if (c[1:0] == 2'd2) invert[1:0] = 2'd1;
  endfunction

  // Move i of a batch-boundary request: [U] ++ undo(b-1) ++ setup(b).
  function automatic logic [4:0] move_at(input logic [3:0] b, input logic [3:0] i);
    logic [3:0] ub;
    logic [3:0] lu;
    logic [3:0] j;
    ub = b - 4'd1;
    lu = setup_len(ub);
    j  = i - 4'd1;
    if (i == 4'd0)  move_at = U_CW;
    else if (j < lu) move_at = invert(pick(setup_list(ub), lu - 4'd1 - j));
    else            move_at = pick(setup_list(b), j - lu);
  endfunction

  function automatic logic [3:0] list_len(input logic [5:0] n);
    if (n == 6'd0)            list_len = 4'd0;
    else if (n[1:0] != 2'd0)  list_len = 4'd1;
    else                      list_len = 4'd1 + setup_len(n[5:2] - 4'd1) + setup_len(n[5:2]);
  endfunction

  state_t     state_q, state_d;
  logic [5:0] step_q, step_d;
  logic [5:0] cur_n_q, cur_n_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] len_q, len_d;
  logic [4:0] code_q, code_d;
  logic       stable_q, stable_d;
  logic       done_q, done_d;
  logic       perr_q, perr_d;
  logic [3:0] nxt_ptr;
`ifdef SCAN_SETTLE_TIMER_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cur_n_d  = cur_n_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    code_d   = code_q;
    stable_d = 1'b0;
    done_d   = done_q;
    perr_d   = perr_q;
    nxt_ptr  = ptr_q + 4'd1;
`ifdef SCAN_SETTLE_TIMER_EN
    cnt_d    = cnt_q;
`endif
    // A request coinciding with the stable pulse counts as busy.
    if (send_setup_moves && (((state_q != WAIT_REQ) && (state_q != FINISHED)) || stable_q))
      perr_d = 1'b1;
    case (state_q)
      WAIT_REQ: if (send_setup_moves && !stable_q) state_d = LOAD;
      LOAD: begin
        cur_n_d = step_q;
        ptr_d   = 4'd0;
        len_d   = list_len(step_q);
        code_d  = move_at(step_q[5:2], 4'd0);
        if (step_q != 6'd49) step_d = step_q + 6'd1;
        state_d = (list_len(step_q) == 4'd0) ? SETTLE : ISSUE;
      end
      ISSUE: if (move_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (move_done) begin
          if (nxt_ptr == len_q) begin
            if (cur_n_q == 6'd48) begin
              state_d = FINISHED;
              done_d  = 1'b1;
            end else begin
              state_d = SETTLE;
            end
          end else begin
            ptr_d   = nxt_ptr;
            code_d  = move_at(cur_n_q[5:2], nxt_ptr);
            state_d = ISSUE;
          end
        end
      end
      SETTLE: begin
`ifdef SCAN_SETTLE_TIMER_EN
        if (cnt_q == 16'd0) begin
          stable_d = 1'b1;
          state_d  = WAIT_REQ;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
`else
        stable_d = 1'b1;
        state_d  = WAIT_REQ;
`endif
      end
      FINISHED: state_d = FINISHED;
      default:  state_d = WAIT_REQ;
    endcase
`ifdef SCAN_SETTLE_TIMER_EN
    if ((state_d == SETTLE) && (state_q != SETTLE)) cnt_d = SETTLE_CYCLES - 16'd1;
`endif
  end

  // State and output registers; reset abandons any move in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= WAIT_REQ;
      step_q   <= 6'd0;
      cur_n_q  <= 6'd0;
      ptr_q    <= 4'd0;
      len_q    <= 4'd0;
      code_q   <= 5'd0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
`ifdef SCAN_SETTLE_TIMER_EN
      cnt_q    <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cur_n_q  <= cur_n_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      code_q   <= code_d;
      stable_q <= stable_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
`ifdef SCAN_SETTLE_TIMER_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign move_valid          = (state_q == ISSUE);
  assign move_code           = code_q;
  assign color_sensor_stable = stable_q;
  assign step                = step_q;
  assign scan_done           = done_q;
  assign protocol_error      = perr_q;

endmodule

// File: tb/tb_scan_move_sequencer.sv
// Purpose: scoreboard bench for scan_move_sequencer (schedule, handshake hold, finish, errors, reset).
// Latency: settle delay follows SCAN_SETTLE_TIMER_EN (SETTLE_CYCLES=4 when defined, one cycle otherwise).
// Backpressure: the motor model holds move_ready low for a configurable number of cycles.
`timescale 1ns/1ps
module tb_scan_move_sequencer;

  localparam logic [15:0] SETTLE = 16'd4;
`ifdef SCAN_SETTLE_TIMER_EN
  localparam int EFF_S = 4;
`else
  localparam int EFF_S = 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       send_setup_moves;
  logic       move_ready;
  logic       move_done;
  logic       move_valid;
  logic [4:0] move_code;
  logic       color_sensor_stable;
  logic [5:0] step;
  logic       scan_done;
  logic       protocol_error;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int model_step;
  logic [4:0] exp_q[$];
  logic [4:0] st [0:11][0:5];
  int         sl [0:11];

  scan_move_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .send_setup_moves    (send_setup_moves),
    .move_ready          (move_ready),
    .move_done           (move_done),
    .move_valid          (move_valid),
    .move_code           (move_code),
    .color_sensor_stable (color_sensor_stable),
    .step                (step),
    .scan_done           (scan_done),
    .protocol_error      (protocol_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] mk(input byte f, input int t);
    logic [2:0] face;
    case (f)
      "U":     face = 3'd0;
      "L":     face = 3'd1;
      "F":     face = 3'd2;
      "R":     face = 3'd3;
      "B":     face = 3'd4;
      default: face = 3'd5;
    endcase
    return {face, t[1:0]};
  endfunction

  // Parse cube notation such as "F B' L2" into the batch table.
  task automatic set_batch(input int b, input string s);
    int n;
    byte c;
    n = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "'")      st[b][n-1][1:0] = 2'd2;
      else if (c == "2") st[b][n-1][1:0] = 2'd3;
      else if (c != " ") begin
        st[b][n] = mk(c, 1);
        n++;
      end
    end
    sl[b] = n;
  endtask

  function automatic logic [4:0] inv(input logic [4:0] c);
    logic [4:0] r;
    r = c;
    if (c[1:0] != 2'd3) r[1:0] = 2'd3 - c[1:0];
    return r;
  endfunction

  task automatic push_expected(input int n);
    int b;
    if (n != 0 && n <= 48) begin
      exp_q.push_back(5'b00001);
      if (n % 4 == 0) begin
        b = n / 4;
        for (int i = sl[b-1] - 1; i >= 0; i--) exp_q.push_back(inv(st[b-1][i]));
        if (b < 12) for (int i = 0; i < sl[b]; i++) exp_q.push_back(st[b][i]);
      end
    end
  endtask

  // One full request: issue it, serve every move, then check the stable pulse (or finish).
  task automatic run_request(input int hold, input bit inject);
    int n, want, guard, j_cyc, stray;
    logic [4:0] exp;
    bit held_ok;
    n = model_step;
    push_expected(n);
    want = exp_q.size();
    move_ready = (hold == 0);
    @(negedge clock);
    send_setup_moves = 1'b1;
    @(negedge clock);
    send_setup_moves = 1'b0;
    j_cyc = cyc + 1;
    if (model_step < 49) model_step++;
    for (int m = 0; m < want; m++) begin
      guard = 0;
      while (!move_valid && guard < 20) begin @(negedge clock); guard++; end
      exp = exp_q.pop_front();
      chk_cnt++;
      if (move_valid !== 1'b1 || move_code !== exp)
        $display("FAIL move n=%0d idx=%0d: valid=%b code=%b, want valid=1 code=%b", n, m, move_valid, move_code, exp);
      else pass_cnt++;
      if (hold > 0) begin
        held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
          @(negedge clock);
          if (move_valid !== 1'b1 || move_code !== exp) held_ok = 1'b0;
        end
        chk_cnt++;
        if (!held_ok) $display("FAIL move_hold n=%0d idx=%0d: code=%b valid=%b, want held %b", n, m, move_code, move_valid, exp);
        else pass_cnt++;
        move_ready = 1'b1;
        @(negedge clock);
        move_ready = 1'b0;
      end else begin
        @(negedge clock);
      end
      chk_cnt++;
      if (move_valid !== 1'b0) $display("FAIL valid_drop n=%0d idx=%0d: valid=%b, want 0", n, m, move_valid);
      else pass_cnt++;
      if (inject && m == 0) begin
        send_setup_moves = 1'b1;
        @(negedge clock);
        send_setup_moves = 1'b0;
      end else begin
        @(negedge clock);
      end
      @(negedge clock);
      move_done = 1'b1;
      @(negedge clock);
      move_done = 1'b0;
      j_cyc = cyc;
    end
    if (n == 48) begin
      stray = 0;
      repeat (EFF_S + 4) begin
        @(negedge clock);
        if (color_sensor_stable !== 1'b0 || move_valid !== 1'b0) stray++;
      end
      chk_cnt++;
      if (stray != 0) $display("FAIL finish_quiet: %0d active cycles, want 0", stray);
      else pass_cnt++;
      chk_cnt++;
      if (scan_done !== 1'b1) $display("FAIL scan_done: got %b, want 1", scan_done);
      else pass_cnt++;
    end else begin
      guard = 0;
      while (color_sensor_stable !== 1'b1 && guard < EFF_S + 10) begin @(negedge clock); guard++; end
      chk_cnt++;
      if (color_sensor_stable !== 1'b1 || cyc != j_cyc + EFF_S)
        $display("FAIL stable_time n=%0d: stable=%b offset=%0d, want 1 at offset %0d", n, color_sensor_stable, cyc - j_cyc, EFF_S);
      else pass_cnt++;
      @(negedge clock);
      chk_cnt++;
      if (color_sensor_stable !== 1'b0 || move_valid !== 1'b0)
        $display("FAIL stable_width n=%0d: stable=%b valid=%b, want 0 0", n, color_sensor_stable, move_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    send_setup_moves = 1'b0;
    move_ready = 1'b1;
    move_done = 1'b0;
    model_step = 0;
    repeat (3) @(negedge clock);
    chk_cnt++;
    if ({move_valid, move_code, color_sensor_stable, step, scan_done, protocol_error} !== 15'd0)
      $display("FAIL reset_outputs: got %b, want all zero",
               {move_valid, move_code, color_sensor_stable, step, scan_done, protocol_error});
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_request0();
    run_request(0, 1'b0);
    chk_cnt++;
    if (step !== 6'd1) $display("FAIL step_after_req0: got %0d, want 1", step);
    else pass_cnt++;
  endtask

  task automatic test_single_move();
    run_request(0, 1'b0);
    chk_cnt++;
    if (step !== 6'd2) $display("FAIL step_after_req1: got %0d, want 2", step);
    else pass_cnt++;
  endtask

  task automatic test_hold_sequence();
    while (model_step < 28) run_request(0, 1'b0);
    run_request(3, 1'b0);
    chk_cnt++;
    if (step !== 6'd29) $display("FAIL step_after_req28: got %0d, want 29", step);
    else pass_cnt++;
    while (model_step < 48) run_request(0, 1'b0);
  endtask

  task automatic test_finish();
    int act;
    run_request(0, 1'b0);
    chk_cnt++;
    if (step !== 6'd49) $display("FAIL step_final: got %0d, want 49", step);
    else pass_cnt++;
    @(negedge clock);
    send_setup_moves = 1'b1;
    @(negedge clock);
    send_setup_moves = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clock);
      if (move_valid !== 1'b0 || color_sensor_stable !== 1'b0) act++;
    end
    chk_cnt++;
    if (act != 0) $display("FAIL extra_request_activity: %0d cycles, want 0", act);
    else pass_cnt++;
    chk_cnt++;
    if (protocol_error !== 1'b0) $display("FAIL finished_no_error: got %b, want 0", protocol_error);
    else pass_cnt++;
    chk_cnt++;
    if (step !== 6'd49 || scan_done !== 1'b1)
      $display("FAIL finished_hold: step=%0d scan_done=%b, want 49 1", step, scan_done);
    else pass_cnt++;
  endtask

  task automatic test_protocol_error();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_q.delete();
    model_step = 0;
    while (model_step < 5) run_request(0, 1'b0);
    run_request(0, 1'b1);
    chk_cnt++;
    if (protocol_error !== 1'b1) $display("FAIL protocol_error_set: got %b, want 1", protocol_error);
    else pass_cnt++;
    chk_cnt++;
    if (step !== 6'd6) $display("FAIL step_after_busy_req: got %0d, want 6", step);
    else pass_cnt++;
    run_request(0, 1'b0);
    run_request(0, 1'b0);
    chk_cnt++;
    if (protocol_error !== 1'b1) $display("FAIL protocol_error_sticky: got %b, want 1", protocol_error);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_issue();
    int guard;
    move_ready = 1'b0;
    @(negedge clock);
    send_setup_moves = 1'b1;
    @(negedge clock);
    send_setup_moves = 1'b0;
    guard = 0;
    while (!move_valid && guard < 20) begin @(negedge clock); guard++; end
    chk_cnt++;
    if (move_valid !== 1'b1 || move_code !== 5'b00001)
      $display("FAIL req8_offer: valid=%b code=%b, want 1 00001", move_valid, move_code);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({move_valid, move_code, color_sensor_stable, step, scan_done, protocol_error} !== 15'd0)
      $display("FAIL async_reset_outputs: got %b, want all zero",
               {move_valid, move_code, color_sensor_stable, step, scan_done, protocol_error});
    else pass_cnt++;
    @(negedge clock);
    reset_n = 1'b1;
    exp_q.delete();
    model_step = 0;
    run_request(0, 1'b0);
    chk_cnt++;
    if (step !== 6'd1 || protocol_error !== 1'b0)
      $display("FAIL post_reset_req0: step=%0d perr=%b, want 1 0", step, protocol_error);
    else pass_cnt++;
  endtask

  initial begin
    set_batch(0, "");
    set_batch(1, "F B'");
    set_batch(2, "L' R");
    set_batch(3, "F' B");
    set_batch(4, "L R'");
    set_batch(5, "L2 R2");
    set_batch(6, "");
    set_batch(7, "F B' L U F B'");
    set_batch(8, "L' R F U' L' R");
    set_batch(9, "F' B R U F' B");
    set_batch(10, "L R' B' U L R'");
    set_batch(11, "R2 L2 F2 B2");
    test_reset();
    test_request0();
    test_single_move();
    test_hold_sequence();
    test_finish();
    test_protocol_error();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/scan_move_sequencer.md
# scan_move_sequencer

Responder to `determine_state`'s `send_setup_moves` pulses during cube scanning. Each pulse selects the next sensor-observation step. The block drives the motor layer with the required face turns one at a time, waits for the cube to settle, then pulses `color_sensor_stable` so the next sticker can be sampled. It encodes the fixed 48-observation schedule: 24 corners, then 24 edges, in 12 batches of 4.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16'd5000: clock cycles to wait after the last `move_done` before pulsing stable.

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `send_setup_moves` in 1: one-cycle request for the next observation step.
- `move_ready` in 1: motor layer accepts `move_code` while `move_valid` is high.
- `move_done` in 1: one-cycle pulse when the accepted move physically completes.
- `move_valid` out 1: a move is offered.
- `move_code` out 5: bits [4:2] are the face (U=0, L=1, F=2, R=3, B=4, D=5); bits [1:0] are the turn (1 = CW, 2 = CCW, 3 = half).
- `color_sensor_stable` out 1: one-cycle pulse; the sensors may be read.
- `step` out 6: number of requests accepted so far (0..49, saturating).
- `scan_done` out 1: level; the final restore is complete.
- `protocol_error` out 1: sticky; a request arrived while busy.

## Operation
- **States:**
  - `WAIT_REQ`: idle.
  - `LOAD`: build the move list for this step.
  - `ISSUE`: `move_valid=1`.
  - `WAIT_DONE`: wait for the motor to finish.
  - `SETTLE`: count down.
  - `FINISHED`: scan complete.
- **Batch setup lists,** where b is the batch index (b<6 corners, b≥6 edges):
  - b0: none.
  - b1: F B'.
  - b2: L' R.
  - b3: F' B.
  - b4: L R'.
  - b5: L2 R2.
  - b6: none.
  - b7: F B' L U F B'.
  - b8: L' R F U' L' R.
  - b9: F' B R U F' B.
  - b10: L R' B' U L R'.
  - b11: R2 L2 F2 B2.
- **Undo of a batch:** the setup list in reverse order, with each CW↔CCW swapped; half turns are unchanged.
- **Move list for request n** (n = `step` before increment):
  - n%4≠0: [U].
  - n=0: setup(b0), which is empty.
  - n%4=0, 0<n<48: [U] ++ undo(n/4−1) ++ setup(n/4).
  - n=48: [U] ++ undo(11), then enter `FINISHED`.
  - Maximum list length is 13 moves.
- **Empty move list:** go straight from `LOAD` to `SETTLE`.
- **Issuing a move:**
  - Hold `move_valid` and `move_code` stable until a cycle with `move_ready=1`.
  - That cycle is the handshake; then deassert `move_valid` and enter `WAIT_DONE`.
  - On `move_done`, issue the next move, or enter `SETTLE` when the list is exhausted.
- **`SETTLE`:** the counter loads `SETTLE_CYCLES`−1 and decrements to 0. On the 0 cycle, assert `color_sensor_stable` for exactly one cycle and return to `WAIT_REQ`.
- **Request arriving outside `WAIT_REQ`:** the request is ignored and sets `protocol_error`.
- **`FINISHED`:**
  - `scan_done=1`, no further moves, no stable pulses.
  - Further requests are ignored without error.
- **`move_done` outside `WAIT_DONE`:** ignored.
- **Reset (any time, including mid-move):** all outputs return to 0, `step=0`, state is `WAIT_REQ`, and the list pointer is cleared. A move already accepted by the motor is abandoned; the motor layer handles its own reset.

## Timing
- **Request to `LOAD`:** a request sampled high at edge k gives `LOAD` at k. `move_valid` rises at edge k+1, or `SETTLE` starts at k+1 for an empty list.
- **Request to stable, empty list:** the stable pulse occurs at edge k+1+`SETTLE_CYCLES`.
- **Move handshake:** `move_valid` may be combinationally fed from state, but `move_code` must be registered. The handshake completes in the cycle both `move_valid` and `move_ready` are high; `move_valid` is low the following cycle.
- **`move_done` to next move:** `move_done` at edge j gives the next `move_valid=1` at edge j+1.
- **Request and stable in the same cycle:** cannot occur legally. If it does, the request is treated as busy and `protocol_error` is set.
- **`step`:** increments in the `LOAD` cycle.

## Configuration
- **`SCAN_SETTLE_TIMER_EN` defined:** `SETTLE` counts as described.
- **`SCAN_SETTLE_TIMER_EN` undefined:**
  - `SETTLE` lasts exactly one cycle; stable pulses on the cycle after the last `move_done`, or after `LOAD` for an empty list.
  - `SETTLE_CYCLES` is unused.
  - No counter register is synthesized.

## Test plan
- **Reset, then request 0** (`SETTLE_CYCLES`=4, `move_ready` tied high): no `move_valid`; stable pulses 5 cycles after the request; `step`=1.
- **Request 1:** one move, `move_code`=5'b00001 (U CW). After `move_done`, stable pulses once, after `SETTLE_CYCLES`.
- **Requests up to n=28** (undo b6, setup b7): the sequence is U, then F B' L U F B'. Check each code, with `move_ready` held low 3 cycles on each move to confirm `move_code` holds.
- **Request 48:** U, then B2 F2 L2 R2. No stable pulse; `scan_done`=1. A 50th request produces nothing and `protocol_error` stays 0.
- **Request pulsed during `WAIT_DONE`:** ignored; `protocol_error`=1 until reset; the move sequence is unaffected.
- **`reset_n` low mid-`ISSUE`** at request 8: all outputs 0 asynchronously. After release, the next request behaves as request 0.
